high_score_table: RTL and testbench

- Parametrised successor to the single-entry high-score block.
- Keeps a sorted table of the DEPTH best scores.
- On game over, inserts the final score with a multi-cycle search/shift FSM and converts it to BCD with a sequential double-dabble.
- Flags a live new best during play and renders the table as a DEPTH-row by DIGITS-column character field; digit glyphs come from the external digit bitmap.

---
 rtl/high_score_table_if.sv | 35 +++
 rtl/high_score_table.sv | 198 +++++++++++++++++++
 tb/tb_high_score_table.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/high_score_table_if.sv
// Game-event, score and pixel/display signals of the high-score table.
// The bench drives through master; the table block attaches as slave.
interface high_score_table_if #(
  parameter int unsigned SCORE_W = 32,
  parameter int unsigned DEPTH   = 4
);
  localparam int unsigned RANK_W = $clog2(DEPTH + 1);

  logic               startOfFrame;
  logic               startGame;
  logic               gameOver;
  logic [10:0]        pixelX;
  logic [10:0]        pixelY;
  logic [SCORE_W-1:0] score;
  logic               newHighScore;
  logic               busy;
  logic               insertDone;
  logic [RANK_W-1:0]  insertRank;
  logic               drawingRequest;
  logic [3:0]         digitValue;
  logic [2:0]         charOffsetX;
  logic [3:0]         charOffsetY;

  modport master (
    output startOfFrame, startGame, gameOver, pixelX, pixelY, score,
    input  newHighScore, busy, insertDone, insertRank,
           drawingRequest, digitValue, charOffsetX, charOffsetY
  );

  modport slave (
    input  startOfFrame, startGame, gameOver, pixelX, pixelY, score,
    output newHighScore, busy, insertDone, insertRank,
           drawingRequest, digitValue, charOffsetX, charOffsetY
  );
endinterface

// File: rtl/high_score_table.sv
// Sorted DEPTH-entry high-score table with search/shift insertion, sequential
// binary-to-BCD conversion and a DEPTH x DIGITS character-field renderer.
module high_score_table #(
  parameter int unsigned SCORE_W    = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DIGITS     = 8,
  parameter int unsigned TOP_LEFT_X = 560,
  parameter int unsigned TOP_LEFT_Y = 11
) (
  input logic              clk,
  input logic              resetN,
  high_score_table_if.slave bus
);
  localparam int unsigned RANK_W  = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned BCD_W   = 4 * DIGITS;
  localparam int unsigned CNT_W   = $clog2(SCORE_W + 1);
  localparam int unsigned FIELD_W = DIGITS * 8;
  localparam int unsigned FIELD_H = DEPTH * 16;

  typedef enum logic [2:0] {
    S_IDLE, S_SEARCH, S_SHIFT, S_WRITE, S_CONVERT, S_DONE
  } state_t;

  state_t             r_state;
  logic [SCORE_W-1:0] r_table [DEPTH];
  logic [BCD_W-1:0]   r_bcd   [DEPTH];
  logic [SCORE_W-1:0] r_s;
  logic [SCORE_W-1:0] r_sh;
  logic [BCD_W-1:0]   r_dd;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_i;
  logic [IDX_W-1:0]   r_j;
  logic [IDX_W-1:0]   r_wr;
  logic [RANK_W-1:0]  r_rank;
  logic               r_busy;
  logic               r_done;
  logic               r_new_high;
  logic               r_hold;
  logic               r_draw;
  logic [3:0]         r_digit;
  logic [2:0]         r_off_x;
  logic [3:0]         r_off_y;

  logic [BCD_W-1:0]   w_dd_adj;
  logic [BCD_W-1:0]   w_dd_next;

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next bit.
  always_comb begin
    w_dd_adj = r_dd;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (r_dd[4*k +: 4] >= 4'd5) w_dd_adj[4*k +: 4] = r_dd[4*k +: 4] + 4'd3;
    end
    w_dd_next = {w_dd_adj[BCD_W-2:0], r_sh[SCORE_W-1]};
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state <= S_IDLE;
      for (int k = 0; k < int'(DEPTH); k++) begin
        r_table[k] <= '0;
        r_bcd[k]   <= '0;
      end
      r_s    <= '0;
      r_sh   <= '0;
      r_dd   <= '0;
      r_cnt  <= '0;
      r_i    <= '0;
      r_j    <= '0;
      r_wr   <= '0;
      r_rank <= RANK_W'(DEPTH);
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.gameOver) begin
            r_s     <= bus.score;
            r_i     <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SEARCH;
          end
        end
        // Strict compare so an equal score lands below the existing entry.
        S_SEARCH: begin
          if (r_s > r_table[r_i]) begin
            r_wr    <= r_i;
            r_j     <= IDX_W'(DEPTH - 1);
            r_state <= (r_i == IDX_W'(DEPTH - 1)) ? S_WRITE : S_SHIFT;
          end else if (r_i == IDX_W'(DEPTH - 1)) begin
            r_rank  <= RANK_W'(DEPTH);
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_i <= r_i + IDX_W'(1);
          end
        end
        S_SHIFT: begin
          r_table[r_j] <= r_table[r_j - IDX_W'(1)];
          r_bcd[r_j]   <= r_bcd[r_j - IDX_W'(1)];
          if (r_j == r_wr + IDX_W'(1)) r_state <= S_WRITE;
          else                         r_j     <= r_j - IDX_W'(1);
        end
        S_WRITE: begin
          r_table[r_wr] <= r_s;
          r_sh          <= r_s;
          r_dd          <= '0;
          r_cnt         <= '0;
          r_state       <= S_CONVERT;
        end
        S_CONVERT: begin
          r_dd <= w_dd_next;
          r_sh <= {r_sh[SCORE_W-2:0], 1'b0};
          if (r_cnt == CNT_W'(SCORE_W - 1)) begin
            r_bcd[r_wr] <= w_dd_next;
            r_rank      <= RANK_W'(r_wr);
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Live best-score flag; frozen from game over until the next game starts.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_new_high <= 1'b0;
      r_hold     <= 1'b0;
    end else if (bus.startGame) begin
      r_new_high <= 1'b0;
      r_hold     <= 1'b0;
    end else begin
      if (bus.gameOver)                     r_hold     <= 1'b1;
      if (bus.startOfFrame && !r_hold)      r_new_high <= (bus.score > r_table[0]);
    end
  end

  logic [10:0]      w_dx;
  logic [10:0]      w_dy;
  logic             w_in;
  logic [BCD_W-1:0] w_row_bcd;
  logic [3:0]       w_digit;
  logic             w_nz;
  int               w_didx;

  assign w_dx = bus.pixelX - 11'(TOP_LEFT_X);
  assign w_dy = bus.pixelY - 11'(TOP_LEFT_Y);
  assign w_in = (bus.pixelX >= 11'(TOP_LEFT_X)) && (w_dx < 11'(FIELD_W)) &&
                (bus.pixelY >= 11'(TOP_LEFT_Y)) && (w_dy < 11'(FIELD_H));

  // Column 0 is the most significant digit; zeros above the top non-zero digit blank.
  always_comb begin
    w_row_bcd = '0;
    w_digit   = '0;
    w_nz      = 1'b0;
    w_didx    = int'(DIGITS) - 1 - int'(w_dx[10:3]);
    if (w_in) begin
      w_row_bcd = r_bcd[IDX_W'(w_dy[10:4])];
      for (int k = 0; k < int'(DIGITS); k++) begin
        if (k == w_didx) w_digit = w_row_bcd[4*k +: 4];
        if (k >= w_didx && w_row_bcd[4*k +: 4] != 4'd0) w_nz = 1'b1;
      end
      if (w_didx == 0) w_nz = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_draw  <= 1'b0;
      r_digit <= '0;
      r_off_x <= '0;
      r_off_y <= '0;
    end else begin
      r_draw  <= w_in && w_nz && !r_busy;
      r_digit <= w_digit;
      r_off_x <= w_dx[2:0];
      r_off_y <= w_dy[3:0];
    end
  end

  assign bus.newHighScore   = r_new_high;
  assign bus.busy           = r_busy;
  assign bus.insertDone     = r_done;
  assign bus.insertRank     = r_rank;
  assign bus.drawingRequest = r_draw;
  assign bus.digitValue     = r_digit;
  assign bus.charOffsetX    = r_off_x;
  assign bus.charOffsetY    = r_off_y;
endmodule

// File: tb/tb_high_score_table.sv
// Self-checking bench for high_score_table: sorted-list reference model,
// decimal-arithmetic display expectations and randomized insertions.
module tb_high_score_table;
  localparam int unsigned SCORE_W = 32;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned DIGITS  = 8;
  localparam int unsigned TLX     = 560;
  localparam int unsigned TLY     = 11;
  localparam int          LSD_X   = TLX + (DIGITS - 1) * 8;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  high_score_table_if #(.SCORE_W(SCORE_W), .DEPTH(DEPTH)) bus ();

  high_score_table #(
    .SCORE_W(SCORE_W), .DEPTH(DEPTH), .DIGITS(DIGITS),
    .TOP_LEFT_X(TLX), .TOP_LEFT_Y(TLY)
  ) dut (
    .clk(clk), .resetN(resetN), .bus(bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [SCORE_W-1:0] model [DEPTH];

  // Sorted-list insert: first slot strictly beaten; returns DEPTH when not entered.
  function automatic int model_insert(input logic [SCORE_W-1:0] s);
    int r = DEPTH;
    for (int i = DEPTH - 1; i >= 0; i--) if (s > model[i]) r = i;
    if (r < DEPTH) begin
      for (int j = DEPTH - 1; j > r; j--) model[j] = model[j-1];
      model[r] = s;
    end
    return r;
  endfunction

  function automatic int exp_cycles(input int r);
    return (r < DEPTH) ? (r + 1) + (DEPTH - 1 - r) + 1 + SCORE_W + 1 : DEPTH + 1;
  endfunction

  function automatic logic [3:0] dec_digit(input logic [SCORE_W-1:0] v, input int k);
    longint unsigned x = longint'(v);
    for (int i = 0; i < k; i++) x = x / 10;
    return 4'(x % 10);
  endfunction

  function automatic logic [4*DIGITS-1:0] exp_digits(input logic [SCORE_W-1:0] v);
    logic [4*DIGITS-1:0] d;
    for (int k = 0; k < DIGITS; k++) d[4*k +: 4] = dec_digit(v, k);
    return d;
  endfunction

  function automatic logic [DIGITS-1:0] exp_mask(input logic [SCORE_W-1:0] v);
    logic [DIGITS-1:0] m;
    for (int k = 0; k < DIGITS; k++) begin
      m[k] = (k == 0);
      for (int n = k; n < DIGITS; n++) if (dec_digit(v, n) != 4'd0) m[k] = 1'b1;
    end
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.startOfFrame = 1'b0;
    bus.startGame    = 1'b0;
    bus.gameOver     = 1'b0;
    bus.score        = '0;
    bus.pixelX       = '0;
    bus.pixelY       = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetN = 1'b0;
    tick();
    tick();
    resetN = 1'b1;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic probe(input int x, input int y, output logic dr, output logic [3:0] dv,
                       output logic [2:0] ox, output logic [3:0] oy);
    bus.pixelX = 11'(x);
    bus.pixelY = 11'(y);
    tick();
    dr = bus.drawingRequest;
    dv = bus.digitValue;
    ox = bus.charOffsetX;
    oy = bus.charOffsetY;
  endtask

  task automatic read_row(input int r, output logic [4*DIGITS-1:0] dig, output logic [DIGITS-1:0] drw);
    logic dr; logic [3:0] dv; logic [2:0] ox; logic [3:0] oy;
    for (int c = 0; c < DIGITS; c++) begin
      probe(TLX + c * 8 + (c % 8), TLY + r * 16 + ((c * 3) % 16), dr, dv, ox, oy);
      dig[4*(DIGITS-1-c) +: 4] = dv;
      drw[DIGITS-1-c]          = dr;
    end
  endtask

  // Launches one insertion and follows it until busy drops (bounded).
  task automatic do_insert(input logic [SCORE_W-1:0] s, output int cycles, output int n_done,
                           output int rank_seen, output bit drew_busy);
    bus.pixelX   = 11'(LSD_X);
    bus.pixelY   = 11'(TLY);
    bus.score    = s;
    bus.gameOver = 1'b1;
    tick();
    bus.gameOver = 1'b0;
    bus.score    = SCORE_W'($urandom);
    cycles = 0; n_done = 0; rank_seen = -1; drew_busy = 1'b0;
    while (bus.busy === 1'b1 && cycles < 500) begin
      if (bus.insertDone === 1'b1) begin
        n_done++;
        rank_seen = int'(bus.insertRank);
      end
      if (cycles > 0 && bus.drawingRequest !== 1'b0) drew_busy = 1'b1;
      cycles++;
      tick();
    end
  endtask

  task automatic check_insert(input string name, input logic [SCORE_W-1:0] s);
    int cyc, nd, rk, er; bit db;
    er = model_insert(s);
    do_insert(s, cyc, nd, rk, db);
    n_tests++;
    if (rk != er || nd != 1) begin
      n_fail++;
      $display("FAIL %s rank: score=%0d got rank %0d (%0d done pulses) expected rank %0d (1 pulse)", name, s, rk, nd, er);
    end
    n_tests++;
    if (cyc != exp_cycles(er)) begin
      n_fail++;
      $display("FAIL %s busy_cycles: score=%0d got %0d expected %0d", name, s, cyc, exp_cycles(er));
    end
    n_tests++;
    if (db || int'(bus.insertRank) != er) begin
      n_fail++;
      $display("FAIL %s held_rank/blank_while_busy: rank %0d drew_busy %0d expected %0d 0", name, bus.insertRank, db, er);
    end
  endtask

  task automatic check_rows(input string name);
    logic [4*DIGITS-1:0] d; logic [DIGITS-1:0] w;
    for (int r = 0; r < DEPTH; r++) begin
      read_row(r, d, w);
      n_tests++;
      if (d !== exp_digits(model[r]) || w !== exp_mask(model[r])) begin
        n_fail++;
        $display("FAIL %s row%0d: got digits %h mask %b expected %h %b", name, r, d, w,
                 exp_digits(model[r]), exp_mask(model[r]));
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.pixelX = 11'(LSD_X);
    bus.pixelY = 11'(TLY);
    resetN = 1'b0;
    tick();
    n_tests++;
    if (bus.busy !== 1'b0 || bus.insertDone !== 1'b0 || bus.newHighScore !== 1'b0 ||
        bus.drawingRequest !== 1'b0 || int'(bus.insertRank) != DEPTH) begin
      n_fail++;
      $display("FAIL reset_outputs: busy %b done %b nh %b draw %b rank %0d expected 0 0 0 0 %0d",
               bus.busy, bus.insertDone, bus.newHighScore, bus.drawingRequest, bus.insertRank, DEPTH);
    end
    do_reset();
  endtask

  task automatic test_display();
    logic dr; logic [3:0] dv; logic [2:0] ox; logic [3:0] oy;
    probe(LSD_X, TLY, dr, dv, ox, oy);
    n_tests++;
    if (dr !== 1'b1 || dv !== 4'd0 || ox !== 3'd0 || oy !== 4'd0) begin
      n_fail++;
      $display("FAIL disp_lsd_zero: draw %b digit %0d ox %0d oy %0d expected 1 0 0 0", dr, dv, ox, oy);
    end
    probe(TLX + 1, TLY, dr, dv, ox, oy);
    n_tests++;
    if (dr !== 1'b0 || ox !== 3'd1) begin
      n_fail++;
      $display("FAIL disp_leading_blank: draw %b ox %0d expected 0 1", dr, ox);
    end
    probe(LSD_X + 3, TLY + 3 * 16 + 5, dr, dv, ox, oy);
    n_tests++;
    if (dr !== 1'b1 || ox !== 3'd3 || oy !== 4'd5) begin
      n_fail++;
      $display("FAIL disp_last_row: draw %b ox %0d oy %0d expected 1 3 5", dr, ox, oy);
    end
    probe(TLX - 1, TLY, dr, dv, ox, oy);
    n_tests++;
    if (dr !== 1'b0) begin n_fail++; $display("FAIL disp_left_edge: draw %b expected 0", dr); end
    probe(TLX + DIGITS * 8, TLY, dr, dv, ox, oy);
    n_tests++;
    if (dr !== 1'b0) begin n_fail++; $display("FAIL disp_right_edge: draw %b expected 0", dr); end
    probe(LSD_X, TLY + DEPTH * 16, dr, dv, ox, oy);
    n_tests++;
    if (dr !== 1'b0) begin n_fail++; $display("FAIL disp_bottom_edge: draw %b expected 0", dr); end
    probe(LSD_X, TLY - 1, dr, dv, ox, oy);
    n_tests++;
    if (dr !== 1'b0) begin n_fail++; $display("FAIL disp_top_edge: draw %b expected 0", dr); end
  endtask

  task automatic test_insert_sequence();
    check_insert("seq1234", 32'd1234);
    check_insert("seq500a", 32'd500);
    check_insert("seq9999", 32'd9999);
    check_insert("seq500b", 32'd500);
    n_tests++;
    if (model[0] != 9999 || model[1] != 1234 || model[2] != 500 || model[3] != 500 ||
        int'(bus.insertRank) != 3) begin
      n_fail++;
      $display("FAIL seq_table: rank %0d expected 3 with table 9999,1234,500,500", bus.insertRank);
    end
    check_rows("seq");
  endtask

  task automatic test_not_entered();
    check_insert("not_entered", 32'd100);
    check_rows("not_entered");
  endtask

  task automatic test_truncation();
    logic [4*DIGITS-1:0] d; logic [DIGITS-1:0] w;
    check_insert("trunc", 32'd123456789);
    read_row(0, d, w);
    n_tests++;
    if (d !== 32'h23456789 || w !== 8'hFF) begin
      n_fail++;
      $display("FAIL trunc_row0: got %h mask %b expected 23456789 11111111", d, w);
    end
    check_rows("trunc");
  endtask

  task automatic pulse_frame(input logic [SCORE_W-1:0] s);
    bus.score = s;
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
  endtask

  task automatic test_new_high();
    int cyc, nd, rk, er;
    do_reset();
    check_insert("nh_seed", 32'd500);
    bus.startGame = 1'b1; tick(); bus.startGame = 1'b0;
    pulse_frame(32'd501);
    n_tests++;
    if (bus.newHighScore !== 1'b1) begin n_fail++; $display("FAIL nh_501: got %b expected 1", bus.newHighScore); end
    pulse_frame(32'd400);
    n_tests++;
    if (bus.newHighScore !== 1'b0) begin n_fail++; $display("FAIL nh_400: got %b expected 0", bus.newHighScore); end
    pulse_frame(32'd501);
    bus.score = 32'd501; bus.gameOver = 1'b1; tick(); bus.gameOver = 1'b0;
    er = model_insert(32'd501);
    pulse_frame(32'd0);
    n_tests++;
    if (bus.newHighScore !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL nh_held: nh %b busy %b expected 1 1", bus.newHighScore, bus.busy);
    end
    bus.score = 32'd999; bus.gameOver = 1'b1; tick(); bus.gameOver = 1'b0;
    bus.startGame = 1'b1; tick(); bus.startGame = 1'b0;
    n_tests++;
    if (bus.newHighScore !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL nh_startgame_busy: nh %b busy %b expected 0 1", bus.newHighScore, bus.busy);
    end
    cyc = 0; nd = 0; rk = -1;
    while (cyc < 200) begin
      if (bus.insertDone === 1'b1) begin nd++; rk = int'(bus.insertRank); end
      cyc++;
      tick();
    end
    n_tests++;
    if (nd != 1 || rk != er || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL nh_single_insert: pulses %0d rank %0d busy %b expected 1 %0d 0", nd, rk, bus.busy, er);
    end
    check_rows("nh");
    pulse_frame(32'd600);
    n_tests++;
    if (bus.newHighScore !== 1'b1) begin n_fail++; $display("FAIL nh_new_game: got %b expected 1", bus.newHighScore); end
  endtask

  task automatic test_reset_mid();
    int nd;
    bus.score = 32'd700; bus.gameOver = 1'b1; tick(); bus.gameOver = 1'b0;
    tick();
    resetN = 1'b0;
    tick();
    n_tests++;
    if (bus.busy !== 1'b0 || bus.insertDone !== 1'b0 || int'(bus.insertRank) != DEPTH) begin
      n_fail++;
      $display("FAIL reset_mid: busy %b done %b rank %0d expected 0 0 %0d", bus.busy, bus.insertDone, bus.insertRank, DEPTH);
    end
    resetN = 1'b1;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    nd = 0;
    for (int c = 0; c < 60; c++) begin
      if (bus.insertDone !== 1'b0 || bus.busy !== 1'b0) nd++;
      tick();
    end
    n_tests++;
    if (nd != 0) begin n_fail++; $display("FAIL reset_mid_quiet: got %0d active cycles expected 0", nd); end
    check_rows("reset_mid");
  endtask

  task automatic test_random();
    logic [SCORE_W-1:0] s;
    do_reset();
    for (int n = 0; n < 12; n++) begin
      s = ($urandom_range(0, 2) == 0) ? SCORE_W'($urandom) : SCORE_W'($urandom_range(0, 30));
      check_insert($sformatf("rand%0d", n), s);
    end
    check_rows("rand");
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_display();
    test_insert_sequence();
    test_not_entered();
    test_truncation();
    test_new_high();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
